demux_fifo_cuatrobits: RTL

DEMUX_FIFO_CUATROBITS -- requirements
Module: demux_fifo_cuatrobits

---
 rtl/demux_fifo_cuatrobits_pkg.sv | 21 ++
 rtl/demux_fifo_cuatrobits_fifo.sv | 69 ++++++
 rtl/demux_fifo_cuatrobits.sv | 74 +++++++
 3 files changed

// File: rtl/demux_fifo_cuatrobits_pkg.sv
// Shared widths and defaults for the two-lane 4-bit demux FIFO.
// Lane request bundles keep the per-lane steering in the top level readable.
package demux_fifo_cuatrobits_pkg;

  localparam int DATA_W         = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int NUM_LANES      = 2;

  typedef struct packed {
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
  } lane_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
  } lane_rsp_t;

endpackage

// File: rtl/demux_fifo_cuatrobits_fifo.sv
// Single-lane show-ahead FIFO: dout always presents the oldest entry.
// Push is refused when full and pop is ignored when empty, so neither side can corrupt the count.
module fifo_cuatrobits
  import demux_fifo_cuatrobits_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [AW:0]                   count_q, count_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic                          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale contents are never visible past an empty flag.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/demux_fifo_cuatrobits.sv
// 1-to-2 demux feeding two independent FIFOs; selector picks the destination lane.
// Top level only steers pushes, derives ready_in and zero-masks empty lane outputs.
module demux_fifo_cuatrobits
  import demux_fifo_cuatrobits_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              selector,
  output logic              ready_in,
  input  logic              pop0,
  input  logic              pop1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              full0,
  output logic              full1,
  output logic              empty0,
  output logic              empty1
);

  lane_req_t [NUM_LANES-1:0]              req;
  lane_rsp_t [NUM_LANES-1:0]              rsp;
  logic      [NUM_LANES-1:0]              pop_v;
  logic      [NUM_LANES-1:0]              full_v;
  logic      [NUM_LANES-1:0][DATA_W-1:0]  dout_m;

  assign pop_v = {pop1, pop0};

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) full_v[i] = rsp[i].full;
  end

  assign ready_in = ~full_v[selector];

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      // A word lands only in the addressed lane, and only when that lane has room.
      assign req[i].push = valid_in & ready_in & (int'(selector) == i);
      assign req[i].pop  = pop_v[i];
      assign req[i].din  = data_in;

      fifo_cuatrobits #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req[i].push),
        .pop   (req[i].pop),
        .din   (req[i].din),
        .dout  (rsp[i].dout),
        .full  (rsp[i].full),
        .empty (rsp[i].empty)
      );

      assign dout_m[i] = rsp[i].empty ? '0 : rsp[i].dout;
    end
  endgenerate

  assign data_out0  = dout_m[0];
  assign data_out1  = dout_m[1];
  assign valid_out0 = ~rsp[0].empty;
  assign valid_out1 = ~rsp[1].empty;
  assign full0      = rsp[0].full;
  assign full1      = rsp[1].full;
  assign empty0     = rsp[0].empty;
  assign empty1     = rsp[1].empty;

endmodule
